// File: rtl/aead_host_pkg.sv
// Shared definitions for the AEAD serial host: FSM state encoding, load-length
// computation and (with AEAD_HOST_VERIFY_EN) the random-bit LFSR constants.
package aead_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_LOAD,
        ST_WAIT,
        ST_CAP,
        ST_DONE
`ifdef AEAD_HOST_VERIFY_EN
        ,
        ST_VWAIT,
        ST_VCAP
`endif
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Core load length: every serial field is shifted in over the same window.
    function automatic int unsigned calc_n(input int unsigned k, input int unsigned l,
                                           input int unsigned y);
        return max2(max2(k, 128), max2(l, y));
    endfunction

`ifdef AEAD_HOST_VERIFY_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif

endpackage

// File: rtl/aead_serial_host_if.sv
// Parallel job/result bus of the AEAD serial host.
//   master : controller side (offers jobs, consumes results)
//   slave  : host side (accepts jobs, presents ciphertext and tag)
interface aead_serial_host_if #(
    parameter int unsigned K = 128,
    parameter int unsigned L = 40,
    parameter int unsigned Y = 40
) ();
    logic           in_valid;
    logic           in_ready;
    logic [K-1:0]   key_in;
    logic [127:0]   nonce_in;
    logic [L-1:0]   ad_in;
    logic [Y-1:0]   pt_in;
    logic           out_valid;
    logic           out_ready;
    logic [Y-1:0]   ct_out;
    logic [127:0]   tag_out;

    modport master (
        output in_valid, key_in, nonce_in, ad_in, pt_in, out_ready,
        input  in_ready, out_valid, ct_out, tag_out
    );

    modport slave (
        input  in_valid, key_in, nonce_in, ad_in, pt_in, out_ready,
        output in_ready, out_valid, ct_out, tag_out
    );
endinterface

// File: rtl/aead_host_shift.sv
// Generic W-bit shift register used both as a parallel-in MSB-first serialiser
// (load_i then shl_i, serial bit is q_o[W-1]) and as an LSB-first deserialiser
// (shr_i with ser_i entering at the MSB; after W shifts the first bit sits at q_o[0]).
// Ports: clk, rst (sync, active-low), load_i/par_i, shl_i, shr_i/ser_i, q_o.
module aead_host_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] par_i,
    input  logic         shl_i,
    input  logic         shr_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i)
            q_d = par_i;
        else if (shl_i)
            q_d = {q_q[W-2:0], 1'b0};
        else if (shr_i)
            q_d = {ser_i, q_q[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/aead_serial_host.sv
// Host-side driver for the bit-serial AEAD core. Accepts one parallel job over
// the bus (slave modport), pulses the core reset, shifts key/nonce/AD/plaintext
// MSB-first for N cycles, holds enc_start until the core is ready, then captures
// ciphertext and tag LSB-first and presents them until consumed.
// Ports: clk, rst (sync, active-low), bus (job/result handshake), core_rst,
//   *_so serial outputs to the core, *_si serial inputs from the core.
// Optional macro AEAD_HOST_VERIFY_EN: adds a decrypt/verify pass (VWAIT/VCAP),
//   the auth_ok output and an LFSR feeding r128_so/rpt_so.
module aead_serial_host
    import aead_host_pkg::*;
#(
    parameter int unsigned K = 128,
    parameter int unsigned L = 40,
    parameter int unsigned Y = 40
) (
    input  logic               clk,
    input  logic               rst,
    aead_serial_host_if.slave  bus,
    output logic               core_rst,
    output logic               key_so,
    output logic               nonce_so,
    output logic               ad_so,
    output logic               pt_so,
    output logic               r128_so,
    output logic               rpt_so,
    output logic               enc_start_so,
    output logic               dec_start_so,
    input  logic               ct_si,
    input  logic               tag_si,
    input  logic               enc_ready_si,
    input  logic               dec_ready_si,
    input  logic               pt_si,
    input  logic               dtag_si,
    input  logic               auth_si
`ifdef AEAD_HOST_VERIFY_EN
    ,
    output logic               auth_ok
`endif
);
    localparam int unsigned N  = calc_n(K, L, Y);
    localparam int unsigned M  = max2(Y, 128);
    localparam int unsigned CW = $clog2(max2(N, M) + 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(M - 1);
    localparam logic [CW-1:0] Y_LIM     = CW'(Y);
    localparam logic [CW-1:0] T_LIM     = CW'(128);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            take;
    logic            loading;
    logic [K-1:0]    key_sh;
    logic [127:0]    nonce_sh;
    logic [L-1:0]    ad_sh;
    logic [Y-1:0]    pt_sh;
    logic [Y-1:0]    ct_q;
    logic [127:0]    tag_q;
`ifdef AEAD_HOST_VERIFY_EN
    logic            auth_q, auth_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [Y-1:0]    pt_chk;
    logic [127:0]    tag_chk;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
`ifdef AEAD_HOST_VERIFY_EN
        auth_d  = auth_q;
`endif
        case (state_q)
            ST_IDLE: if (bus.in_valid) begin
                take    = 1'b1;
                state_d = ST_CRST;
            end
            ST_CRST: begin
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LOAD_LAST)
                    state_d = ST_WAIT;
            end
            ST_WAIT: if (enc_ready_si) begin
                cnt_d   = '0;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CAP_LAST)
`ifdef AEAD_HOST_VERIFY_EN
                    state_d = ST_VWAIT;
`else
                    state_d = ST_DONE;
`endif
            end
`ifdef AEAD_HOST_VERIFY_EN
            ST_VWAIT: if (dec_ready_si) begin
                cnt_d   = '0;
                auth_d  = auth_si;
                state_d = ST_VCAP;
            end
            ST_VCAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CAP_LAST)
                    state_d = ST_DONE;
            end
`endif
            ST_DONE: if (bus.out_ready)
                state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
`ifdef AEAD_HOST_VERIFY_EN
            auth_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef AEAD_HOST_VERIFY_EN
            auth_q  <= auth_d;
`endif
        end
    end

    assign loading = (state_q == ST_LOAD);

    // Load-side serialisers: shifting left with zero fill makes a narrow
    // field output 0 once its W bits have gone out.
    aead_host_shift #(.W(K)) u_key (
        .clk(clk), .rst(rst), .load_i(take), .par_i(bus.key_in),
        .shl_i(loading), .shr_i(1'b0), .ser_i(1'b0), .q_o(key_sh));
    aead_host_shift #(.W(128)) u_nonce (
        .clk(clk), .rst(rst), .load_i(take), .par_i(bus.nonce_in),
        .shl_i(loading), .shr_i(1'b0), .ser_i(1'b0), .q_o(nonce_sh));
    aead_host_shift #(.W(L)) u_ad (
        .clk(clk), .rst(rst), .load_i(take), .par_i(bus.ad_in),
        .shl_i(loading), .shr_i(1'b0), .ser_i(1'b0), .q_o(ad_sh));
    aead_host_shift #(.W(Y)) u_pt (
        .clk(clk), .rst(rst), .load_i(take), .par_i(bus.pt_in),
        .shl_i(loading), .shr_i(1'b0), .ser_i(1'b0), .q_o(pt_sh));

    // Capture-side deserialisers: shift only for the field's own width so bit j
    // lands at index j even though CAP runs max(Y,128) cycles.
    aead_host_shift #(.W(Y)) u_ct (
        .clk(clk), .rst(rst), .load_i(1'b0), .par_i('0), .shl_i(1'b0),
        .shr_i(state_q == ST_CAP && cnt_q < Y_LIM), .ser_i(ct_si), .q_o(ct_q));
    aead_host_shift #(.W(128)) u_tag (
        .clk(clk), .rst(rst), .load_i(1'b0), .par_i('0), .shl_i(1'b0),
        .shr_i(state_q == ST_CAP && cnt_q < T_LIM), .ser_i(tag_si), .q_o(tag_q));

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.ct_out    = ct_q;
    assign bus.tag_out   = tag_q;

    assign core_rst     = !(state_q == ST_IDLE || state_q == ST_CRST);
    assign key_so       = loading & key_sh[K-1];
    assign nonce_so     = loading & nonce_sh[127];
    assign ad_so        = loading & ad_sh[L-1];
    assign pt_so        = loading & pt_sh[Y-1];
    assign enc_start_so = (state_q == ST_WAIT);

`ifdef AEAD_HOST_VERIFY_EN
    aead_host_shift #(.W(Y)) u_ptchk (
        .clk(clk), .rst(rst), .load_i(1'b0), .par_i('0), .shl_i(1'b0),
        .shr_i(state_q == ST_VCAP && cnt_q < Y_LIM), .ser_i(pt_si), .q_o(pt_chk));
    aead_host_shift #(.W(128)) u_tagchk (
        .clk(clk), .rst(rst), .load_i(1'b0), .par_i('0), .shl_i(1'b0),
        .shr_i(state_q == ST_VCAP && cnt_q < T_LIM), .ser_i(dtag_si), .q_o(tag_chk));

    // Reseeded per job so every load sees the same random sequence.
    always_comb begin
        lfsr_d = lfsr_q;
        if (take)
            lfsr_d = LFSR_SEED;
        else if (loading)
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end

    assign r128_so      = loading & lfsr_q[15];
    assign rpt_so       = loading & lfsr_q[0];
    assign dec_start_so = (state_q == ST_VWAIT);
    assign auth_ok      = auth_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, key_sh[K-2:0], nonce_sh[126:0], ad_sh[L-2:0],
                         pt_sh[Y-2:0], pt_chk, tag_chk};
`else
    assign r128_so      = 1'b0;
    assign rpt_so       = 1'b0;
    assign dec_start_so = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, key_sh[K-2:0], nonce_sh[126:0], ad_sh[L-2:0],
                         pt_sh[Y-2:0], dec_ready_si, pt_si, dtag_si, auth_si};
`endif
endmodule

// File: tb/tb_aead_serial_host.sv
// Self-checking bench for aead_serial_host. A behavioural core stub collects
// the serial load, computes a toy cipher over what it received and returns the
// result serially; expectations come from the same toy cipher applied to the
// job inputs directly.
module tb_aead_serial_host;
    localparam int unsigned K = 128;
    localparam int unsigned L = 40;
    localparam int unsigned Y = 40;
    localparam int unsigned N = 128;
    localparam int unsigned M = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic core_rst, key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so;
    logic enc_start_so, dec_start_so;
    logic ct_si, tag_si, enc_ready_si, dec_ready_si, pt_si, dtag_si, auth_si;
`ifdef AEAD_HOST_VERIFY_EN
    logic auth_ok;
`endif

    aead_serial_host_if #(.K(K), .L(L), .Y(Y)) bus ();

    aead_serial_host #(.K(K), .L(L), .Y(Y)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_rst(core_rst), .key_so(key_so), .nonce_so(nonce_so), .ad_so(ad_so),
        .pt_so(pt_so), .r128_so(r128_so), .rpt_so(rpt_so),
        .enc_start_so(enc_start_so), .dec_start_so(dec_start_so),
        .ct_si(ct_si), .tag_si(tag_si), .enc_ready_si(enc_ready_si),
        .dec_ready_si(dec_ready_si), .pt_si(pt_si), .dtag_si(dtag_si), .auth_si(auth_si)
`ifdef AEAD_HOST_VERIFY_EN
        , .auth_ok(auth_ok)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Toy cipher standing in for the real core.
    function automatic logic [39:0] model_ct(input logic [127:0] k, input logic [39:0] a,
                                             input logic [39:0] p);
        return p ^ k[39:0] ^ a;
    endfunction

    function automatic logic [127:0] model_tag(input logic [127:0] k, input logic [127:0] n,
                                               input logic [39:0] a, input logic [39:0] p);
        return k ^ n ^ {p, 88'h0} ^ {88'h0, a};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_abort(input string where);
        rst = 1'b0;
        step();
        check_eq({where, "_abort_out_valid"}, bus.out_valid, 1'b0);
        check_eq({where, "_abort_in_ready"}, bus.in_ready, 1'b1);
        check_eq({where, "_abort_core_rst"}, core_rst, 1'b0);
        check_eq({where, "_abort_ct_out"}, bus.ct_out, '0);
        check_eq({where, "_abort_so"}, {enc_start_so, key_so, nonce_so, ad_so, pt_so}, '0);
        rst = 1'b1;
    endtask

    // abort_at: 0 = run to completion, 1 = reset mid-LOAD, 2 = reset mid-CAP
    task automatic run_job(input logic [127:0] k, input logic [127:0] n,
                           input logic [39:0] a, input logic [39:0] p,
                           input int wcyc, input int hold, input bit pattern,
                           input int abort_at);
        logic [127:0] rk, rn, stag, exp_tag;
        logic [39:0]  ra, rp, sct, exp_ct;
        int bad, tail;
`ifdef AEAD_HOST_VERIFY_EN
        logic av;
`endif
        rk = '0; rn = '0; ra = '0; rp = '0;
        check_eq("idle_in_ready", bus.in_ready, 1'b1);
        bus.key_in = k; bus.nonce_in = n; bus.ad_in = a; bus.pt_in = p;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_eq("crst_core_rst", core_rst, 1'b0);
        check_eq("crst_in_ready", bus.in_ready, 1'b0);
        step();

        bad = 0; tail = 0;
        for (int c = 0; c < N; c++) begin
            if (c == 0) check_eq("load_core_rst", core_rst, 1'b1);
            if (abort_at == 1 && c == 60) begin
                do_abort("load");
                return;
            end
            rk[127-c] = key_so;
            rn[127-c] = nonce_so;
            if (c < 40) begin
                ra[39-c] = ad_so;
                rp[39-c] = pt_so;
            end else if (ad_so || pt_so) begin
                tail++;
            end
            if (enc_start_so || !core_rst) bad++;
`ifndef AEAD_HOST_VERIFY_EN
            if (r128_so || rpt_so || dec_start_so) bad++;
`endif
            step();
        end
        check_eq("key_ser", rk, k);
        check_eq("nonce_ser", rn, n);
        check_eq("ad_ser", ra, a);
        check_eq("pt_ser", rp, p);
        check_eq("ad_pt_tail_zero", tail, 0);
        check_eq("load_quiet", bad, 0);
        check_eq("load_len_wait", enc_start_so, 1'b1);

        bad = 0;
        for (int w = 0; w < wcyc; w++) begin
            if (!enc_start_so) bad++;
            step();
        end
        check_eq("wait_start_held", bad, 0);
        enc_ready_si = 1'b1;
        step();
        enc_ready_si = 1'b0;
        check_eq("cap_start_drop", enc_start_so, 1'b0);

        sct  = model_ct(rk, ra, rp);
        stag = model_tag(rk, rn, ra, rp);
        for (int j = 0; j < M; j++) begin
            if (abort_at == 2 && j == 70) begin
                do_abort("cap");
                return;
            end
            if (j < Y) ct_si = pattern ? j[0] : sct[j];
            else       ct_si = 1'($urandom_range(0, 1));
            tag_si = stag[j];
            step();
        end
        ct_si = 1'b0; tag_si = 1'b0;

`ifdef AEAD_HOST_VERIFY_EN
        check_eq("vwait_dec_start", dec_start_so, 1'b1);
        av = 1'($urandom_range(0, 1));
        dec_ready_si = 1'b1; auth_si = av;
        step();
        dec_ready_si = 1'b0; auth_si = 1'b0;
        for (int j = 0; j < M; j++) begin
            pt_si   = (j < Y) ? rp[j] : 1'b0;
            dtag_si = stag[j];
            step();
        end
        pt_si = 1'b0; dtag_si = 1'b0;
        check_eq("pt_chk", dut.pt_chk, p);
        check_eq("auth_ok", auth_ok, av);
`endif

        exp_ct  = pattern ? 40'hAAAAAAAAAA : model_ct(k, a, p);
        exp_tag = model_tag(k, n, a, p);
        check_eq("done_out_valid", bus.out_valid, 1'b1);
        check_eq("done_ct_out", bus.ct_out, exp_ct);
        check_eq("done_tag_out", bus.tag_out, exp_tag);
        check_eq("done_in_ready", bus.in_ready, 1'b0);

        bad = 0;
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'(h & 1);
            bus.key_in    = rand128();
            bus.pt_in     = rand128();
            step();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.ct_out !== exp_ct || bus.tag_out !== exp_tag) bad++;
        end
        check_eq("done_hold_stable", bad, 0);

        // Offer a junk job in the same cycle as the result is consumed.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq("release_out_valid", bus.out_valid, 1'b0);
        check_eq("release_in_ready", bus.in_ready, 1'b1);
        check_eq("release_core_rst", core_rst, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.key_in = '0; bus.nonce_in = '0; bus.ad_in = '0; bus.pt_in = '0;
        ct_si = 1'b0; tag_si = 1'b0; enc_ready_si = 1'b0;
        dec_ready_si = 1'b0; pt_si = 1'b0; dtag_si = 1'b0; auth_si = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_ct_out", bus.ct_out, '0);
        check_eq("rst_tag_out", bus.tag_out, '0);
        check_eq("rst_core_rst", core_rst, 1'b0);
        check_eq("rst_so", {key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so,
                            enc_start_so, dec_start_so}, '0);
        rst = 1'b1;
        step();

        run_job(128'h000102030405060708090A0B0C0D0E0F, 128'h0F0E0D0C0B0A09080706050403020100,
                40'h4153434F4E, 40'h48656C6C6F, 3, 0, 1'b0, 0);
        run_job(rand128(), rand128(), 40'(rand128()), 40'(rand128()), 50, 20, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            run_job(rand128(), rand128(), 40'(rand128()), 40'(rand128()),
                    $urandom_range(0, 20), $urandom_range(0, 5), 1'b0, 0);
        run_job(rand128(), rand128(), 40'(rand128()), 40'(rand128()), 2, 0, 1'b0, 1);
        run_job(rand128(), rand128(), 40'(rand128()), 40'(rand128()), 5, 1, 1'b0, 0);
        run_job(rand128(), rand128(), 40'(rand128()), 40'(rand128()), 4, 0, 1'b0, 2);
        run_job(rand128(), rand128(), 40'(rand128()), 40'(rand128()), 0, 2, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aead_serial_host.md
Name: aead_serial_host

Overview:
- Host-side driver for the bit-serial AEAD core: takes one parallel job (key, nonce, AD, plaintext) over a valid/ready handshake.
- Owns the core's reset. Serialises the job onto the core's serial inputs and raises encryption start.
- Deserialises the core's serial ciphertext and tag back into parallel words, and returns them over a valid/ready handshake.
- Sits between a bus-facing controller and the AEAD core; one job per core reset.

Parameters:
- K, 128: key width.
- L, 40: associated-data width.
- Y, 40: plaintext/ciphertext width.
- N, max(K,128,L,Y): load length. Derived localparam, not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (one clock; polarity and synchronicity fixed)
- in_valid  in  1  job offered
- in_ready  out  1  host idle, accepts job
- key_in  in  K  key
- nonce_in  in  128  nonce
- ad_in  in  L  associated data
- pt_in  in  Y  plaintext
- out_valid  out  1  result held
- out_ready  in  1  result consumed
- ct_out  out  Y  ciphertext
- tag_out  out  128  tag
- core_rst  out  1  core reset, active-low
- key_so, nonce_so, ad_so, pt_so  out  1 each  serial data to core
- r128_so, rpt_so  out  1 each  random bits to core
- enc_start_so  out  1  core encryption start
- dec_start_so  out  1  core decryption start
- ct_si, tag_si  in  1 each  serial ciphertext/tag from core
- enc_ready_si  in  1  core encryption ready
- dec_ready_si, pt_si, dtag_si, auth_si  in  1 each  decryption outputs (used only with feature)

Behaviour:
- Reset (rst=0), values at the next edge:
  - state=IDLE, in_ready=1, out_valid=0, ct_out=0, tag_out=0.
  - core_rst=0, all *_so=0.
  - Counter cnt=0.
  - Any operation in flight is abandoned; no partial result is ever exposed.
- FSM states: IDLE, CRST, LOAD, WAIT, CAP, DONE (+VWAIT, VCAP with feature).
- IDLE:
  - core_rst=0.
  - Handshake in_valid&in_ready: latch all inputs into shadow registers, in_ready->0, go CRST.
- CRST:
  - One cycle with core_rst=0.
  - Next edge: core_rst=1, cnt=0, go LOAD.
- LOAD, N cycles, cnt=c:
  - Field F of width W drives F[W-1-c] when c<W, else 0. MSB first.
  - Core's first shift edge is the first edge after core_rst=1.
  - At cnt=N-1 go WAIT.
- WAIT:
  - enc_start_so held 1. Core gates start internally until its load count exceeds N, so holding is legal.
  - First cycle enc_ready_si=1 (t0): enc_start_so->0, cnt=0, go CAP.
- CAP, max(Y,128) cycles:
  - Core drives bit j during cycle t0+1+j, LSB first.
  - Host samples ct_si into ct_out[j] for j<Y, and tag_si into tag_out[j] for j<128.
  - Then go DONE.
- DONE:
  - out_valid=1; ct_out/tag_out stable.
  - out_valid&out_ready: out_valid->0, in_ready->1, core_rst->0, go IDLE.
  - in_valid during DONE is ignored (in_ready=0).
- Latency, in_valid handshake to out_valid: 1+N+W+max(Y,128)+1 cycles. W = WAIT dwell, ≥1, core-dependent.
- The core's random inputs r128_so/rpt_so are 0 without the feature.
- in_valid and out_ready may be asserted in the same cycle; only the handshake valid in the current state is honoured.
- No timeout. WAIT holds indefinitely until enc_ready_si.

Optional Feature:
- Macro: AEAD_HOST_VERIFY_EN.
- Enabled:
  - After CAP the FSM enters VWAIT, holding dec_start_so=1 until dec_ready_si.
  - Then VCAP captures pt_si into a Y-bit pt_chk and dtag_si into a 128-bit tag_chk, with the same LSB-first timing as CAP.
  - auth_si is sampled at the first dec_ready_si cycle and drives an extra output port auth_ok (1 bit), valid with out_valid.
  - r128_so/rpt_so are driven from a 16-bit Fibonacci LFSR: taps 16,14,13,11, seed 16'hACE1, advancing every LOAD cycle.
- Disabled: no VWAIT/VCAP states, no auth_ok port, dec_start_so tied 0, no LFSR.

Decomposition:
- Package aead_host_pkg: state enum, N computation function, LFSR seed/taps constants.
- Sub-module aead_host_shift: a generic parallel-in MSB-first serialiser / LSB-first deserialiser, width-parameterised.
  - Instantiated per field for load.
  - Instantiated per output for capture.

Test Plan:
- Reset, then job key=128'h000102..0F, nonce=128'h0F0E..00, ad=40'h4153434F4E, pt=40'h48656C6C6F, with the real AEAD core attached:
  - out_valid rises.
  - ct_out/tag_out match the reference model.
  - core_rst low for exactly one cycle before LOAD.
- Same job, checking bit alignment:
  - key_so sequence over cycles 0..127 equals key bits 127..0.
  - ad_so is 0 after cycle 39.
  - LOAD lasts exactly 128 cycles.
- Core stub delaying enc_ready_si 50 cycles:
  - enc_start_so stays 1 throughout WAIT.
  - Stub serial pattern ct bit j = j[0]: ct_out=40'hAAAAAAAAAA.
- Hold out_ready=0 for 20 cycles in DONE:
  - Outputs stable, in_ready=0, a second in_valid is ignored.
  - Releasing out_ready accepts the next job the cycle after.
- Assert rst=0 mid-LOAD and again mid-CAP:
  - Next cycle state=IDLE, out_valid=0, core_rst=0.
  - A subsequent job completes correctly.
- With AEAD_HOST_VERIFY_EN, same job as the first scenario:
  - pt_chk=40'h48656C6C6F, auth_ok=1.
  - With the stub forcing auth_si=0: auth_ok=0.
